// File: rtl/key_pkg.sv
// Shared constants, width helper and repeat-state type for the keypad conditioning path.
// No datapath here; the repeat-state type is only used when KEY_AUTOREPEAT_EN is defined.
package key_pkg;

  localparam int KEY_DEBOUNCE_CYCLES = 50000;     // 1 ms at 50 MHz
  localparam int KEY_REPEAT_DELAY    = 25000000;
  localparam int KEY_REPEAT_PERIOD   = 10000000;
  localparam int KEY_CANCEL_IDX      = 3;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int key_width(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Keypad bundle: raw buttons in, debounced levels and one-hot press pulses out.
// Master drives raw buttons; slave (the conditioner) drives levels and pulses. No backpressure.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] keys_raw;
  logic [N_KEYS-1:0] keys_level;
  logic [N_KEYS-1:0] keys_pulse;

  modport master (output keys_raw, input keys_level, input keys_pulse);
  modport slave  (input keys_raw, output keys_level, output keys_pulse);

endinterface

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, level register, rise/fall strobes.
// Level changes DEBOUNCE_CYCLES+2 edges after a stable raw change; strobes are combinational on the accepting cycle.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = key_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          accept;
  logic [CW-1:0] cnt;

  assign accept = (sync2 != level) && (cnt == CNT_LAST);
  assign rise   = accept && sync2;
  assign fall   = accept && !sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any matching sample restarts the count, so a bounce needs a full fresh window.
      if ((sync2 == level) || accept) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
      if (accept) level <= sync2;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounces N_KEYS buttons and emits a registered one-hot press pulse (highest index wins); optional KEY_AUTOREPEAT_EN.
// Press latency DEBOUNCE_CYCLES+2 edges from raw rise; no backpressure, dropped simultaneous presses are not queued.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  key_conditioner_if.slave  kif
);

  logic [N_KEYS-1:0] level_v;
  logic [N_KEYS-1:0] rise_v;
  logic [N_KEYS-1:0] fall_v;
  logic [N_KEYS-1:0] press_oh;
  logic [N_KEYS-1:0] pulse_d;
  logic [N_KEYS-1:0] pulse_q;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (kif.keys_raw[gi]),
      .level (level_v[gi]),
      .rise  (rise_v[gi]),
      .fall  (fall_v[gi])
    );
  end

  // Ascending scan: the last (highest) rising key overwrites any lower one.
  always_comb begin
    press_oh = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (rise_v[i]) begin
        press_oh    = '0;
        press_oh[i] = 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int            KW          = key_width(N_KEYS);
  localparam int            RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            TW          = key_width(RMAX);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  rep_state_t    state_q, state_d;
  logic [KW-1:0] key_q, key_d, press_idx;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rep_fire;
  logic          held;

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (rise_v[i]) press_idx = KW'(i);
    end
  end

  // Held means still high after this edge, so no repeat fires on the releasing edge.
  assign held = level_v[key_q] && !fall_v[key_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    tmr_d    = tmr_q;
    rep_fire = 1'b0;
    if (press_oh != '0) begin
      state_d = DELAY;
      key_d   = press_idx;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        DELAY: begin
          if (!held) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == DELAY_LAST) begin
            rep_fire = 1'b1;
            state_d  = REPEAT;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!held) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == PERIOD_LAST) begin
            rep_fire = 1'b1;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pulse_d = press_oh;
    if ((press_oh == '0) && rep_fire) pulse_d = N_KEYS'(1) << key_q;
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{REPEAT_DELAY, REPEAT_PERIOD, fall_v};
  assign pulse_d    = press_oh;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= '0;
    else        pulse_q <= pulse_d;
  end

  assign kif.keys_level = level_v;
  assign kif.keys_pulse = pulse_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised scoreboard bench for key_conditioner with a window-based reference model.
// Stimulus pushes expected levels/pulses per edge; a monitor pops and compares after each edge.
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int RD   = 8;
  localparam int RP   = 3;
  localparam int MAXE = 4096;

  typedef struct {
    int            e;
    logic [NK-1:0] v;
  } pev_t;

  bit   clk = 1'b1;
  logic rst_n;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  pev_t          pq[$];
  logic [NK-1:0] lq[$];

  // Reference model state: raw value present at each edge, and current level.
  logic [NK-1:0] raw_hist [0:MAXE-1];
  logic [NK-1:0] m_lvl = '0;
  int            n = 0;
  bit            act = 0;
  int            k_idx = 0;
  int            t_acc = 0;
  bit            running = 0;
  bit            done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic raw_at(input int m, input int k);
    if (m < 0) return 1'b0;
    return raw_hist[m][k];
  endfunction

  // Drive inputs for the next edge and predict its outcome.
  task automatic tick(input logic [NK-1:0] raw, input logic rst);
    logic [NK-1:0] nl;
    logic [NK-1:0] rises;
    logic [NK-1:0] pv;
    int            kk;
    bit            stable;
    @(negedge clk);
    running = 1;
    kif.keys_raw = raw;
    if (rst_n && !rst) begin
      rst_n = 1'b0;
      #1;
      chk("reset_level_immediate", kif.keys_level, '0);
      chk("reset_pulse_immediate", kif.keys_pulse, '0);
    end
    rst_n = rst;
    if (n >= MAXE) begin
      $display("FAIL model_capacity: got %0d expected below %0d", n, MAXE);
      $fatal(1, "model history exhausted");
    end
    raw_hist[n] = rst ? raw : '0;
    pv = '0;
    nl = m_lvl;
    kk = 0;
    if (!rst) begin
      if (n >= 1) raw_hist[n-1] = '0;
      if (n >= 2) raw_hist[n-2] = '0;
      nl  = '0;
      act = 0;
    end else begin
      // Level flips once the last DB synchronised samples all disagree with it.
      for (int k = 0; k < NK; k++) begin
        stable = 1;
        for (int j = 0; j < DB; j++)
          if (raw_at(n - 2 - j, k) == m_lvl[k]) stable = 0;
        if (stable) nl[k] = ~m_lvl[k];
      end
      rises = nl & ~m_lvl;
      for (int k = 0; k < NK; k++)
        if (rises[k]) begin
          pv    = '0;
          pv[k] = 1'b1;
          kk    = k;
        end
`ifdef KEY_AUTOREPEAT_EN
      if (pv != '0) begin
        act   = 1;
        k_idx = kk;
        t_acc = n;
      end else if (act) begin
        if (!nl[k_idx]) act = 0;
        else if ((n - t_acc >= RD) && ((n - t_acc - RD) % RP == 0)) pv[k_idx] = 1'b1;
      end
`endif
    end
    m_lvl = nl;
    lq.push_back(nl);
    if (pv != '0) pq.push_back('{n, pv});
    n++;
  endtask

  int            mon_e = 0;
  logic [NK-1:0] el;
  pev_t          pe;

  always @(posedge clk) begin
    #1;
    if (running && !done) begin
      if (lq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL level_queue: got empty expected an entry at edge %0d", mon_e);
      end else begin
        el = lq.pop_front();
        chk("keys_level", kif.keys_level, el);
      end
      if (kif.keys_pulse != '0) begin
        if (pq.size() == 0) begin
          chk("unexpected_pulse", kif.keys_pulse, '0);
        end else begin
          pe = pq.pop_front();
          chk("pulse_edge", mon_e, pe.e);
          chk("pulse_vec", kif.keys_pulse, pe.v);
        end
      end
      mon_e++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [NK-1:0] r;
  logic          cur;
  int            len;

  initial begin
    rst_n        = 1'b0;
    kif.keys_raw = '0;
    repeat (3) tick('0, 1'b0);
    repeat (3) tick('0, 1'b1);

    // Clean press of key 1, then release.
    repeat (20) tick(4'b0010, 1'b1);
    repeat (12) tick('0, 1'b1);

    // Key 0 bouncing with 1-3 cycle pulses, then stable high.
    cur = 1'b0;
    for (int c = 0; c < 15; c += len) begin
      len = $urandom_range(1, 3);
      cur = ~cur;
      repeat (len) tick({3'b000, cur}, 1'b1);
    end
    repeat (15) tick(4'b0001, 1'b1);
    repeat (12) tick('0, 1'b1);

    // Keys 3 and 1 together: only key 3 pulses.
    repeat (12) tick(4'b1010, 1'b1);
    repeat (12) tick('0, 1'b1);

    // Reset while key 2 is mid-count.
    repeat (4) tick(4'b0100, 1'b1);
    tick(4'b0100, 1'b0);
    repeat (12) tick(4'b0100, 1'b1);
    repeat (12) tick('0, 1'b1);

    // Long hold of key 0; level falls before acceptance+20.
    repeat (19) tick(4'b0001, 1'b1);
    repeat (15) tick('0, 1'b1);

    // Random multi-key activity with occasional resets.
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 9) == 0) r[k] = ~r[k];
      tick(r, ($urandom_range(0, 299) != 0));
    end
    repeat (15) tick('0, 1'b1);

    @(posedge clk);
    #2;
    done = 1;
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      $display("FAIL missing_pulse: got none expected %0h at edge %0d", pe.v, pe.e);
      n_cmp++;
      n_bad++;
    end
    chk("level_queue_drained", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions raw push-button inputs for the combination-lock keypad path and sits directly upstream of the lock FSM. Synchronises each asynchronous button, debounces it with a per-key stability counter, and emits a registered, single-cycle, one-hot press pulse per debounced press. The lock consumes this pulse vector as its `buttons` input, so it sees exactly one nonzero cycle per physical press.

## Interface
- `N_KEYS`, 4, number of buttons; index 3 is the cancel key.
- `DEBOUNCE_CYCLES`, 50000, consecutive stable samples required before accepting a level change (1 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, 25000000, hold time before the first auto-repeat pulse; used only with `KEY_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 10000000, spacing between later auto-repeat pulses; used only with `KEY_AUTOREPEAT_EN`.

- `clk` in 1 system clock; all state updates on its rising edge.
- `rst_n` in 1 reset, asynchronous and active-low.
- `keys_raw` in N_KEYS raw buttons, active-high, asynchronous, bouncing.
- `keys_level` out N_KEYS debounced button levels, registered.
- `keys_pulse` out N_KEYS one-hot press pulse, registered, high for exactly one cycle; drives the lock's `buttons`.

## Operation
- Reset (`rst_n` = 0, any time, including mid-count or mid-repeat):
  - Synchroniser flops, counters, `keys_level` and `keys_pulse` clear to 0 immediately.
  - The repeat state returns to IDLE.
  - The first edge after release starts from the all-released state.
- Per key: a two-flop synchroniser produces `s`.
  - While `s` equals `keys_level[i]`, the counter holds 0.
  - While `s` differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and `s` still differs, `keys_level[i]` toggles on that edge and the counter clears.
  - Any sample where `s` matches `keys_level[i]` clears the counter. A bounce restarts the full count.
- Press event: `keys_level[i]` rises on this edge. Release (falling level) never produces a pulse.
- Arbitration: if several press events occur on the same edge, only the highest index pulses. The others are dropped, not queued, but their `keys_level` bits still rise.
- `keys_pulse` is never more than one-hot. It is 0 in every cycle without an accepted event.

## Timing
- `keys_raw[i]` rises, stable before edge 0 → `keys_level[i]` and `keys_pulse[i]` both high after edge DEBOUNCE_CYCLES+1.
  - Latency is DEBOUNCE_CYCLES+2 edges counted from edge 0.
  - The pulse clears on the next edge.
- Release latency is identical: `keys_level` falls DEBOUNCE_CYCLES+2 edges after a stable low.
- A raw glitch shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no level change and no pulse.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter never wraps because it clears at terminal count.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: a repeat FSM with states IDLE, DELAY and REPEAT tracks the last-pulsed key K.
  - IDLE → DELAY on any accepted pulse, which latches K.
  - DELAY → REPEAT after REPEAT_DELAY cycles with `keys_level[K]` high; emit one pulse on K.
  - REPEAT: emit one pulse on K every REPEAT_PERIOD cycles.
  - Any state → IDLE when `keys_level[K]` falls.
  - A new press event on another key preempts: DELAY restarts with the new K, and the new press's pulse takes that cycle.
  - The repeat timer is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) bits wide.
- `KEY_AUTOREPEAT_EN` undefined: no repeat logic is compiled in; exactly one pulse per press.

## Structure
- Package `key_pkg`:
  - default constants DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD;
  - the cancel-key index constant (3);
  - a clog2-based width function;
  - the repeat-state typedef (IDLE/DELAY/REPEAT).
- Sub-module `key_debounce_ch`: a single channel (synchroniser, counter, level register, rise strobe), instantiated N_KEYS times by generate.
- The top level holds the priority arbiter, the pulse register and the optional repeat FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, plus REPEAT_DELAY=8 and REPEAT_PERIOD=3 where auto-repeat is tested.
- Clean press of key 1 held 20 cycles → `keys_level` = 4'b0010 and `keys_pulse` = 4'b0010 for one cycle, exactly 6 edges after the raw rise; no pulse on release.
- Key 0 bouncing with 1- to 3-cycle pulses for 15 cycles, then stable high → exactly one pulse, 6 edges after the last bounce.
- Keys 3 and 1 raised on the same cycle → single pulse 4'b1000; `keys_level` = 4'b1010.
- `rst_n` low for 1 cycle while key 2 is mid-count (counter = 2) → outputs 0 at once; the count restarts, giving a pulse 6 edges after `rst_n` rises.
- With `KEY_AUTOREPEAT_EN`, key 0 held 20 cycles past acceptance → pulses at acceptance, +8, +11, +14, +17; none after release.
- Without `KEY_AUTOREPEAT_EN`, same stimulus → single pulse at acceptance.
